// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port data memory arbiter, A priority, B anti-starvation and locked bursts; perf counters under DM_ARB_PERF_CNT_EN
module dm_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int MAX_WAIT = 4,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_re,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic          stall_pipe,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DM_ARB_PERF_CNT_EN
  ,
  output logic [15:0]   perf_stall_cnt,
  output logic [15:0]   perf_bgnt_cnt
`endif
);
  typedef enum logic {PIPE, BURST} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  localparam logic [3:0] BM = 4'(BURST_MAX);
  state_t state, state_nxt;
  logic [3:0] wait_cnt, burst_cnt;
  logic a_req, burst_ok, gnt_a, gnt_b, a_rv_q, b_rv_q;
  always_comb begin
    a_req = a_re | a_we;
    burst_ok = b_req & b_lock & (burst_cnt < BM);
    gnt_b = !rst & ((state == BURST) ? burst_ok : b_req & ((wait_cnt == MW) | !a_req));
    gnt_a = !rst & a_req & !gnt_b;
    state_nxt = (state == BURST) ? (burst_ok ? BURST : PIPE) : ((gnt_b & b_lock) ? BURST : PIPE);
  end
  assign stall_pipe = !rst & a_req & !gnt_a;
  assign b_gnt = gnt_b;
  assign mem_addr = gnt_b ? b_addr : a_addr;
  assign mem_wdata = gnt_b ? b_wdata : a_wdata;
  assign mem_re = gnt_a ? !a_we : gnt_b & !b_we;
  assign mem_we = gnt_a ? a_we : gnt_b & b_we;
  assign b_rdata = mem_rdata;
  assign a_rvalid = a_rv_q & !rst;
  assign b_rvalid = b_rv_q & !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PIPE;
      wait_cnt <= '0;
      burst_cnt <= '0;
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      burst_cnt <= (state_nxt == BURST) ? ((state == BURST) ? burst_cnt + 4'd1 : 4'd1) : 4'd0;
      wait_cnt <= gnt_b ? 4'd0 :
                  (state == PIPE && gnt_a) ? (b_req ? ((wait_cnt == MW) ? wait_cnt : wait_cnt + 4'd1) : 4'd0) :
                  wait_cnt;
      a_rv_q <= gnt_a & !a_we;
      b_rv_q <= gnt_b & !b_we;
    end
  end
`ifdef DM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_bgnt_cnt <= '0;
    end else begin
      perf_stall_cnt <= (stall_pipe && perf_stall_cnt != 16'hFFFF) ? perf_stall_cnt + 16'd1 : perf_stall_cnt;
      perf_bgnt_cnt <= (gnt_b && perf_bgnt_cnt != 16'hFFFF) ? perf_bgnt_cnt + 16'd1 : perf_bgnt_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed vector table plus multi-cycle sequences for dm_port_arbiter
module tb_dm_port_arbiter;
  logic clk = 1'b0, rst;
  logic a_re, a_we, b_req, b_we, b_lock;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata, mem_rdata;
  logic a_rvalid, stall_pipe, b_gnt, b_rvalid, mem_re, mem_we;
  logic [15:0] b_rdata, mem_addr, mem_wdata;
`ifdef DM_ARB_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_bgnt_cnt;
`endif
  int errors = 0, checks = 0;
  typedef struct {
    logic a_re, a_we;
    logic [15:0] a_addr, a_wdata;
    logic b_req, b_we, b_lock;
    logic [15:0] b_addr, b_wdata;
    logic e_re, e_we;
    logic [15:0] e_addr, e_wdata;
    logic e_gnt, e_stall, e_arv, e_brv;
  } vec_t;
  vec_t v[8];
  dm_port_arbiter dut (
    .clk(clk), .rst(rst), .a_re(a_re), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .stall_pipe(stall_pipe), .b_req(b_req), .b_we(b_we), .b_lock(b_lock),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DM_ARB_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bgnt_cnt(perf_bgnt_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(string n, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask
  task automatic chk16(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle;
    a_re = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
  endtask
  task automatic drive(vec_t x);
    a_re = x.a_re; a_we = x.a_we; a_addr = x.a_addr; a_wdata = x.a_wdata;
    b_req = x.b_req; b_we = x.b_we; b_lock = x.b_lock; b_addr = x.b_addr; b_wdata = x.b_wdata;
  endtask
  task automatic restart;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  logic [8:0] aw, ar, br, eg, es, ewe, ere;
  initial begin
    v[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    v[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    v[2] = '{1'b1, 1'b1, 16'h0008, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    v[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    v[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0200, 16'hBEEF, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    v[5] = '{1'b0, 1'b0, 16'h0077, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0300, 16'hAAAA, 1'b0, 1'b0, 16'h0077, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    v[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0400, 16'h1111, 1'b0, 1'b1, 16'h0400, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0};
    v[7] = '{1'b0, 1'b1, 16'h0010, 16'h2222, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h3333, 1'b0, 1'b1, 16'h0010, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0};
    mem_rdata = 16'hCAFE;
    idle();
    rst = 1'b1;
    a_re = 1'b1;
    b_req = 1'b1;
    tick();
    tick();
    chk1("rst mem_re", mem_re, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk1("rst b_gnt", b_gnt, 1'b0);
    chk1("rst stall", stall_pipe, 1'b0);
    chk1("rst a_rvalid", a_rvalid, 1'b0);
    chk1("rst b_rvalid", b_rvalid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      restart();
      drive(v[i]);
      #1;
      chk1($sformatf("v%0d mem_re", i), mem_re, v[i].e_re);
      chk1($sformatf("v%0d mem_we", i), mem_we, v[i].e_we);
      chk16($sformatf("v%0d mem_addr", i), mem_addr, v[i].e_addr);
      chk16($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].e_wdata);
      chk1($sformatf("v%0d b_gnt", i), b_gnt, v[i].e_gnt);
      chk1($sformatf("v%0d stall", i), stall_pipe, v[i].e_stall);
      tick();
      idle();
      #1;
      chk1($sformatf("v%0d a_rvalid", i), a_rvalid, v[i].e_arv);
      chk1($sformatf("v%0d b_rvalid", i), b_rvalid, v[i].e_brv);
      if (v[i].e_brv) chk16($sformatf("v%0d b_rdata", i), b_rdata, 16'hCAFE);
    end
    restart();
    a_re = 1'b1; a_addr = 16'h0040; b_req = 1'b1; b_addr = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk1($sformatf("starve c%0d b_gnt", c), b_gnt, c == 4 || c == 9);
      chk1($sformatf("starve c%0d stall", c), stall_pipe, c == 4 || c == 9);
      chk16($sformatf("starve c%0d mem_addr", c), mem_addr, (c == 4 || c == 9) ? 16'h0100 : 16'h0040);
      chk1($sformatf("starve c%0d a_rvalid", c), a_rvalid, c > 0 && c != 5);
      chk1($sformatf("starve c%0d b_rvalid", c), b_rvalid, c == 5);
      tick();
    end
    restart();
    aw = 9'b0_0001_1110; ar = 9'b1_1000_0000; br = 9'b1_0111_1111;
    eg = 9'b0_0110_1111; es = 9'b0_0000_1110; ewe = 9'b0_0111_1111; ere = 9'b1_1000_0000;
    a_addr = 16'h0008; b_we = 1'b1; b_lock = 1'b1;
    for (int c = 0; c < 9; c++) begin
      a_we = aw[c]; a_re = ar[c]; b_req = br[c]; b_addr = 16'h0200 + 16'(c);
      #1;
      chk1($sformatf("burst c%0d b_gnt", c), b_gnt, eg[c]);
      chk1($sformatf("burst c%0d stall", c), stall_pipe, es[c]);
      chk1($sformatf("burst c%0d mem_we", c), mem_we, ewe[c]);
      chk1($sformatf("burst c%0d mem_re", c), mem_re, ere[c]);
      chk16($sformatf("burst c%0d mem_addr", c), mem_addr, eg[c] ? 16'h0200 + 16'(c) : 16'h0008);
      tick();
    end
    restart();
    b_req = 1'b1; b_lock = 1'b1; b_addr = 16'h0100; a_addr = 16'h0040;
    #1;
    chk1("rstmid grant", b_gnt, 1'b1);
    tick();
    rst = 1'b1;
    a_re = 1'b1;
    #1;
    chk1("rstmid b_rvalid", b_rvalid, 1'b0);
    chk1("rstmid mem_re", mem_re, 1'b0);
    chk1("rstmid mem_we", mem_we, 1'b0);
    chk1("rstmid b_gnt", b_gnt, 1'b0);
    chk1("rstmid stall", stall_pipe, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("rstpost b_rvalid", b_rvalid, 1'b0);
    chk1("rstpost b_gnt", b_gnt, 1'b0);
    chk1("rstpost mem_re", mem_re, 1'b1);
    chk16("rstpost mem_addr", mem_addr, 16'h0040);
    chk1("rstpost stall", stall_pipe, 1'b0);
    tick();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Port A: the pipeline EX_DM load/store stage (dm_re_EX_DM / dm_we_EX_DM).
  - Port B: the MOVC/LWI and PUSH/POP micro-sequencer.
- Issues at most one memory access per cycle.
- Port A has priority. Port B is protected from starvation by a wait counter.
- Port B may lock the port for short bursts. The arbiter stalls the pipeline whenever port A is denied.

Parameters:
- AW, 16, memory address width
- DW, 16, memory data width
- MAX_WAIT, 4, consecutive cycles B may wait before it is forced ahead of A (1..15)
- BURST_MAX, 4, maximum consecutive B grants in a locked burst (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- a_re  in  1  pipeline load request
- a_we  in  1  pipeline store request
- a_addr  in  AW  pipeline address
- a_wdata  in  DW  pipeline store data
- a_rvalid  out  1  read data for A valid on mem_rdata (registered)
- stall_pipe  out  1  A requested but not granted this cycle (combinational)
- b_req  in  1  sequencer request
- b_we  in  1  1 = write, 0 = read
- b_lock  in  1  request a locked burst
- b_addr  in  AW  sequencer address
- b_wdata  in  DW  sequencer write data
- b_gnt  out  1  B access issued this cycle (combinational)
- b_rvalid  out  1  read data for B valid on b_rdata (registered)
- b_rdata  out  DW  equals mem_rdata
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_re

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- Reset values:
  - state = PIPE
  - wait_cnt = 0, burst_cnt = 0
  - a_rvalid = 0, b_rvalid = 0
- While rst = 1, these are forced to 0: mem_re, mem_we, b_gnt, stall_pipe.
- a_req = a_re | a_we. If both are set, a_we wins and a_re is ignored.
- B protocol: b_req, b_we, b_lock, b_addr and b_wdata must stay stable from assertion until the cycle b_gnt = 1. The access completes in that cycle.
- State PIPE:
  - If b_req and wait_cnt == MAX_WAIT: grant B, and stall_pipe = a_req.
  - Else if a_req: grant A; wait_cnt <= sat(wait_cnt + 1) if b_req, else 0.
  - Else if b_req: grant B.
  - Any B grant clears wait_cnt.
  - A B grant with b_lock = 1 moves to BURST with burst_cnt = 1.
- State BURST:
  - B has absolute priority and stall_pipe = a_req.
  - If b_req & b_lock & burst_cnt < BURST_MAX: grant B and increment burst_cnt.
  - Otherwise grant nothing to B that cycle. Go to PIPE, clear burst_cnt, and serve A if requested.
  - This guarantees A gets at least one cycle after every burst.
- Dropping b_req or b_lock mid-burst returns to PIPE next cycle, with no grant in the exiting cycle.
- Memory interface:
  - mem_addr and mem_wdata mux from the granted port.
  - mem_re = granted & !write; mem_we = granted & write.
  - With no grant: mem_addr and mem_wdata hold port A values, and mem_re = mem_we = 0.
- Read data return:
  - a_rvalid <= (A granted read). b_rvalid <= (B granted read).
  - Each is a one-cycle pulse, so latency is 1 cycle.
  - At most one of a_rvalid and b_rvalid is high in any cycle.
- Writes produce no rvalid.
- Asserting rst mid-burst or with a read in flight drops the read: no rvalid next cycle, and state returns to PIPE.
- wait_cnt saturates at MAX_WAIT and never wraps.

Optional Feature:
- Macro: DM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt [15:0] (cycles with stall_pipe = 1) and perf_bgnt_cnt [15:0] (B grants).
  - Both counters reset to 0 on rst and saturate at 16'hFFFF.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- A read at addr 16'h0040, no B request -> mem_re = 1 and mem_addr = 16'h0040 that cycle; a_rvalid = 1 next cycle; stall_pipe = 0 throughout.
- B read at 16'h0100, A idle -> b_gnt = 1 the same cycle; b_rvalid = 1 next cycle with b_rdata = mem_rdata; a_rvalid = 0.
- A requests continuously and B requests from cycle 0 with MAX_WAIT = 4 -> A granted in cycles 0-3; in cycle 4 b_gnt = 1 and stall_pipe = 1; wait_cnt returns to 0.
- B locked burst of 6 writes with BURST_MAX = 4 and A requesting -> 4 B writes with stall_pipe = 1, then 1 cycle where A is granted and stall_pipe = 0, then the B burst resumes.
- a_re = a_we = 1 at 16'h0008 -> mem_we = 1 and mem_re = 0; no a_rvalid.
- rst asserted in the cycle after a B read grant -> b_rvalid = 0; state = PIPE; all counters 0; mem_re = mem_we = 0 while rst is high.
